fetch_unit: RTL and testbench

// Fetch stage of the pipelined core: owns PCF, drives the instruction-memory request handshake and loads the IF/ID register.
// It consumes the hazard unit's StallF/StallD/FlushD plus the redirects (BranchTakenE, PCSrcW).
// It returns FetchWait so the hazard unit can hold the pipeline while the memory is slow.

---
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns PCF, drives the instruction-memory request handshake
// and loads the IF/ID register. Responses belonging to a PC that was
// redirected away while in flight are discarded, never passed to decode.
module fetch_unit #(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   Reset_n,
    input  logic                   StallF,
    input  logic                   StallD,
    input  logic                   FlushD,
    input  logic                   BranchTakenE,
    input  logic [PC_WIDTH-1:0]    BranchTargetE,
    input  logic                   PCSrcW,
    input  logic [PC_WIDTH-1:0]    ResultW,
    output logic                   ImemReq,
    output logic [PC_WIDTH-1:0]    ImemAddr,
    input  logic                   ImemReady,
    input  logic [INSTR_WIDTH-1:0] ImemRdata,
    output logic [INSTR_WIDTH-1:0] InstrD,
    output logic [PC_WIDTH-1:0]    PCPlus8D,
    output logic                   ValidD,
    output logic                   FetchWait
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pcf_q, pcf_d;
    logic [PC_WIDTH-1:0]    pend_tgt_q, pend_tgt_d;
    logic [INSTR_WIDTH-1:0] hold_q, hold_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    pc8_q, pc8_d;
    logic                   valid_q, valid_d;
    logic                   req_q, req_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;

    logic                   redirect_c;
    logic [PC_WIDTH-1:0]    target_c;
    logic                   avail_c;
    logic                   accept_c;
    logic [INSTR_WIDTH-1:0] resp_c;
    logic                   fetch_wait_c;

    // Redirect selection (execute beats writeback) and decode acceptance
    always_comb begin
        redirect_c   = BranchTakenE | PCSrcW;
        target_c     = BranchTakenE ? BranchTargetE : ResultW;
        avail_c      = ((state_q == ST_REQ) && ImemReady) || (state_q == ST_HOLD);
        resp_c       = (state_q == ST_HOLD) ? hold_q : ImemRdata;
        accept_c     = avail_c & ~StallF & ~StallD & ~FlushD & ~redirect_c;
        fetch_wait_c = (state_q == ST_IDLE) || (state_q == ST_DROP) ||
                       ((state_q == ST_REQ) && !ImemReady);
    end

    // Next state, PCF, hold buffer and pending-redirect target
    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        pend_tgt_d = pend_tgt_q;
        hold_d     = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect_c) pcf_d = target_c;
            end
            ST_REQ: begin
                if (ImemReady) begin
                    if (redirect_c) begin
                        pcf_d = target_c;
                    end else if (accept_c) begin
                        pcf_d = pcf_q + PC_WIDTH'(4);
                    end else begin
                        hold_d  = ImemRdata;
                        state_d = ST_HOLD;
                    end
                end else if (redirect_c) begin
                    // PCF keeps the in-flight address until the stale response drains
                    pend_tgt_d = target_c;
                    state_d    = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (redirect_c) begin
                    pcf_d   = target_c;
                    state_d = ST_REQ;
                end else if (accept_c) begin
                    pcf_d   = pcf_q + PC_WIDTH'(4);
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (redirect_c) pend_tgt_d = target_c;
                if (ImemReady) begin
                    pcf_d   = redirect_c ? target_c : pend_tgt_q;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // IF/ID register update and registered memory request outputs
    always_comb begin
        instr_d = instr_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (StallD) begin
            instr_d = instr_q;
        end else if (accept_c) begin
            instr_d = resp_c;
            pc8_d   = pcf_q + PC_WIDTH'(8);
            valid_d = 1'b1;
        end else begin
            instr_d = '0;
            valid_d = 1'b0;
        end
        req_d  = (state_d == ST_REQ) || (state_d == ST_DROP);
        // In DROP the bus address must stay on the abandoned request
        addr_d = (state_d == ST_DROP) ? addr_q : pcf_d;
    end

    // State registers
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            pcf_q      <= RESET_PC;
            pend_tgt_q <= '0;
            hold_q     <= '0;
            instr_q    <= '0;
            pc8_q      <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            pend_tgt_q <= pend_tgt_d;
            hold_q     <= hold_d;
            instr_q    <= instr_d;
            pc8_q      <= pc8_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    assign ImemReq   = req_q;
    assign ImemAddr  = addr_q;
    assign InstrD    = instr_q;
    assign PCPlus8D  = pc8_q;
    assign ValidD    = valid_q;
    assign FetchWait = fetch_wait_c;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run,
// all checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    logic        clk;
    logic        Reset_n;
    logic        StallF, StallD, FlushD;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] BranchTargetE, ResultW;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD;
    logic [31:0] PCPlus8D;
    logic        ValidD;
    logic        FetchWait;

    int checks = 0;
    int errors = 0;

    // Model: m_fpc is the next program address to deliver; a stale request
    // is one whose PC was abandoned while in flight; m_have means one fetched
    // instruction is parked waiting for decode.
    bit          m_started, m_have, m_stale;
    logic [31:0] m_fpc, m_stale_addr, m_buf;
    logic [31:0] m_instr, m_pc8;
    bit          m_valid;

    fetch_unit #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .Reset_n(Reset_n),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemReady(ImemReady), .ImemRdata(ImemRdata),
        .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
        .FetchWait(FetchWait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_have = 1'b0; m_stale = 1'b0;
        m_fpc = 32'h0; m_stale_addr = 32'h0; m_buf = 32'h0;
        m_instr = 32'h0; m_pc8 = 32'h0; m_valid = 1'b0;
    endtask

    // One cycle: drive inputs, answer memory, check outputs, advance model, clock
    task automatic step(input bit stf, input bit std, input bit fl,
                        input bit bt, input logic [31:0] btg,
                        input bit ps, input logic [31:0] rw, input bit rdy);
        bit          e_req, e_wait, redir, got, avail, acc;
        logic [31:0] tgt, data;
        StallF = stf; StallD = std; FlushD = fl;
        BranchTakenE = bt; BranchTargetE = btg; PCSrcW = ps; ResultW = rw;
        ImemReady = rdy;
        #1;
        ImemRdata = rdy ? mem_f(ImemAddr) : $urandom;
        #1;
        e_req  = m_started && !m_have;
        e_wait = !m_started || m_stale || (e_req && !rdy);
        chk("imem_req", 32'(ImemReq), 32'(e_req));
        if (e_req) chk("imem_addr", ImemAddr, m_stale ? m_stale_addr : m_fpc);
        chk("fetch_wait", 32'(FetchWait), 32'(e_wait));
        chk("valid_d", 32'(ValidD), 32'(m_valid));
        chk("instr_d", InstrD, m_instr);
        if (m_valid) chk("pcplus8_d", PCPlus8D, m_pc8);

        redir = bt || ps;
        tgt   = bt ? btg : rw;
        got   = rdy && e_req;
        avail = (got && !m_stale) || m_have;
        acc   = avail && !stf && !std && !fl && !redir;
        data  = m_have ? m_buf : mem_f(m_fpc);
        if (fl) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end else if (!std) begin
            if (acc) begin
                m_instr = data; m_pc8 = m_fpc + 32'd8; m_valid = 1'b1;
            end else begin
                m_instr = 32'h0; m_valid = 1'b0;
            end
        end
        if (!m_started) begin
            m_started = 1'b1;
            if (redir) m_fpc = tgt;
        end else if (m_stale) begin
            if (redir) m_fpc = tgt;
            if (got) m_stale = 1'b0;
        end else if (m_have) begin
            if (redir) begin
                m_fpc = tgt; m_have = 1'b0;
            end else if (acc) begin
                m_fpc = m_fpc + 32'd4; m_have = 1'b0;
            end
        end else if (redir) begin
            if (!rdy) begin
                m_stale = 1'b1; m_stale_addr = m_fpc;
            end
            m_fpc = tgt;
        end else if (got) begin
            if (acc) m_fpc = m_fpc + 32'd4;
            else begin
                m_have = 1'b1; m_buf = mem_f(m_fpc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input bit rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    task automatic check_reset_outputs();
        chk("rst_imem_req", 32'(ImemReq), 32'h0);
        chk("rst_fetch_wait", 32'(FetchWait), 32'h1);
        chk("rst_valid_d", 32'(ValidD), 32'h0);
        chk("rst_instr_d", InstrD, 32'h0);
        chk("rst_pcplus8_d", PCPlus8D, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; BranchTargetE = 32'h0;
        PCSrcW = 1'b0; ResultW = 32'h0;
        ImemReady = 1'b0; ImemRdata = 32'h0;
        model_reset();
        #2;
        check_reset_outputs();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        Reset_n = 1'b1;

        // Zero-wait streaming from RESET_PC
        idle_step(1'b1);
        chk("first_req", 32'(ImemReq), 32'h1);
        chk("first_addr", ImemAddr, 32'h0);
        idle_step(1'b1);
        chk("stream_valid", 32'(ValidD), 32'h1);
        chk("stream_instr0", InstrD, mem_f(32'h0));
        chk("stream_pc8_0", PCPlus8D, 32'h8);
        chk("stream_addr4", ImemAddr, 32'h4);
        idle_step(1'b1);

        // Slow memory on address 8
        for (int i = 0; i < 3; i++) begin
            idle_step(1'b0);
            chk("slow_addr_held", ImemAddr, 32'h8);
            chk("slow_bubble", 32'(ValidD), 32'h0);
            chk("slow_wait", 32'(FetchWait), 32'h1);
        end
        idle_step(1'b1);
        chk("slow_instr8", InstrD, mem_f(32'h8));
        chk("slow_pc8", PCPlus8D, 32'h10);

        // Stall while address 12 returns
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("hold_req_low", 32'(ImemReq), 32'h0);
        chk("hold_no_wait", 32'(FetchWait), 32'h0);
        chk("hold_instr_kept", InstrD, mem_f(32'h8));
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("hold2_req_low", 32'(ImemReq), 32'h0);
        chk("hold2_instr_kept", InstrD, mem_f(32'h8));
        idle_step(1'b0);
        chk("hold_release_instr", InstrD, mem_f(32'hC));
        chk("hold_release_pc8", PCPlus8D, 32'h14);
        chk("hold_release_addr", ImemAddr, 32'h10);
        idle_step(1'b1);

        // Branch while address 20 is in flight
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        chk("drop_addr_held", ImemAddr, 32'h14);
        chk("drop_wait", 32'(FetchWait), 32'h1);
        idle_step(1'b0);
        chk("drop_addr_held2", ImemAddr, 32'h14);
        idle_step(1'b1);
        chk("drop_new_addr", ImemAddr, 32'h100);
        chk("drop_no_deliver", 32'(ValidD), 32'h0);

        // Execute redirect beats writeback redirect
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
        chk("redirect_prio", ImemAddr, 32'h200);

        // Flush alone clears IF/ID
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("flush_valid", 32'(ValidD), 32'h0);
        chk("flush_instr", InstrD, 32'h0);
        idle_step(1'b1);
        chk("after_flush_instr", InstrD, mem_f(32'h200));
        chk("after_flush_pc8", PCPlus8D, 32'h208);

        // Asynchronous reset in the middle of a drop
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; PCSrcW = 1'b0; ImemReady = 1'b0;
        @(negedge clk);
        Reset_n = 1'b1;
        idle_step(1'b1);
        chk("refetch_addr", ImemAddr, 32'h0);
        chk("refetch_req", 32'(ImemReq), 32'h1);

        // Randomized hazards, redirects and memory latency
        for (int i = 0; i < 1500; i++) begin
            bit          r_stf, r_std, r_fl, r_bt, r_ps, r_rdy;
            logic [31:0] r_btg, r_rw;
            r_stf = ($urandom_range(0, 9) == 0);
            r_std = ($urandom_range(0, 9) == 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            r_bt  = ($urandom_range(0, 19) == 0);
            r_ps  = ($urandom_range(0, 29) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_btg = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            r_rw  = $urandom & 32'h0000_3FFC;
            step(r_stf, r_std, r_fl, r_bt, r_btg, r_ps, r_rw, r_rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
